// File: rtl/wb_dcache_victim_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// wb_dcache_victim_ctrl_if -- LSU/MMU, memory and datapath control bundle. Rev 1.0
//------------------------------------------------------------------------------
interface wb_dcache_victim_ctrl_if #(
  parameter int IDX_BITS = 7
);
  logic                lsummu2dcache_req_i;
  logic                lsummu2dcache_wr_i;
  logic                dcache_flush_i;
  logic                cache_hit_i;
  logic                cache_evict_req_i;
  logic                dcache_valid_i;
  logic                victim_hit_i;
  logic                mem2dcache_ack_i;
  logic                dcache2lsummu_ack_o;
  logic                dcache_flush_ack_o;
  logic                dcache2mem_req_o;
  logic                dcache2mem_wr_o;
  logic                dcache_req_o;
  logic                cache_wr_o;
  logic                cache_line_wr_o;
  logic                cache_line_clean_o;
  logic                cache_wrb_req_o;
  logic                write_to_victim_o;
  logic                write_from_victim_o;
  logic                lsu_victim_mux_sel_o;
  logic [IDX_BITS-1:0] evict_index_o;

  modport slave (
    input  lsummu2dcache_req_i, lsummu2dcache_wr_i, dcache_flush_i, cache_hit_i,
           cache_evict_req_i, dcache_valid_i, victim_hit_i, mem2dcache_ack_i,
    output dcache2lsummu_ack_o, dcache_flush_ack_o, dcache2mem_req_o, dcache2mem_wr_o,
           dcache_req_o, cache_wr_o, cache_line_wr_o, cache_line_clean_o, cache_wrb_req_o,
           write_to_victim_o, write_from_victim_o, lsu_victim_mux_sel_o, evict_index_o
  );

  modport master (
    output lsummu2dcache_req_i, lsummu2dcache_wr_i, dcache_flush_i, cache_hit_i,
           cache_evict_req_i, dcache_valid_i, victim_hit_i, mem2dcache_ack_i,
    input  dcache2lsummu_ack_o, dcache_flush_ack_o, dcache2mem_req_o, dcache2mem_wr_o,
           dcache_req_o, cache_wr_o, cache_line_wr_o, cache_line_clean_o, cache_wrb_req_o,
           write_to_victim_o, write_from_victim_o, lsu_victim_mux_sel_o, evict_index_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_dcache_victim_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// wb_dcache_victim_ctrl -- write-back dcache miss/victim/flush control FSM. Rev 1.0
//------------------------------------------------------------------------------
module wb_dcache_victim_ctrl #(
  parameter int IDX_BITS = 7
) (
  input logic                    clk,
  input logic                    rst,
  wb_dcache_victim_ctrl_if.slave bus
);
  localparam logic [3:0] c_idle        = 4'd0;
  localparam logic [3:0] c_lookup      = 4'd1;
  localparam logic [3:0] c_wrback      = 4'd2;
  localparam logic [3:0] c_vstore      = 4'd3;
  localparam logic [3:0] c_allocate    = 4'd4;
  localparam logic [3:0] c_vfill       = 4'd5;
  localparam logic [3:0] c_replay      = 4'd6;
  localparam logic [3:0] c_flush_rd    = 4'd7;
  localparam logic [3:0] c_flush_chk   = 4'd8;
  localparam logic [3:0] c_flush_wb    = 4'd9;
  localparam logic [3:0] c_flush_clean = 4'd10;
  localparam logic [3:0] c_flush_done  = 4'd11;
  localparam logic [IDX_BITS-1:0] c_idx_max = '1;

  logic [3:0]          r_state;
  logic [3:0]          w_state_nxt;
  logic                r_wr;
  logic                r_vhit;
  logic                r_vclean;
  logic [IDX_BITS-1:0] r_idx;
  logic                w_line_done;
  logic                w_accept;
  logic                w_miss;
  logic                w_lsu_ack, w_flush_ack, w_mem_req, w_mem_wr, w_dreq, w_cwr;
  logic                w_line_wr, w_clean, w_wrb, w_to_v, w_from_v, w_mux;

  assign w_accept = (r_state == c_idle) && !bus.dcache_flush_i && bus.lsummu2dcache_req_i;
  assign w_miss   = (r_state == c_lookup) && !bus.cache_hit_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= c_idle;
      r_wr     <= 1'b0;
      r_vhit   <= 1'b0;
      r_vclean <= 1'b0;
      r_idx    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_wr     <= bus.lsummu2dcache_wr_i;
        r_vhit   <= 1'b0;
        r_vclean <= 1'b0;
      end
      // Victim hit and "valid and clean" are remembered for the states after the write-back
      if (w_miss) begin
        r_vhit   <= bus.victim_hit_i;
        r_vclean <= bus.dcache_valid_i && !bus.cache_evict_req_i;
      end
      if (w_line_done && (r_idx != c_idx_max)) r_idx <= r_idx + 1'b1;
      if (r_state == c_flush_done)             r_idx <= '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_line_done = 1'b0;
    w_lsu_ack   = 1'b0;
    w_flush_ack = 1'b0;
    w_mem_req   = 1'b0;
    w_mem_wr    = 1'b0;
    w_dreq      = 1'b0;
    w_cwr       = 1'b0;
    w_line_wr   = 1'b0;
    w_clean     = 1'b0;
    w_wrb       = 1'b0;
    w_to_v      = 1'b0;
    w_from_v    = 1'b0;
    w_mux       = 1'b0;
    case (r_state)
      c_idle: begin
        if (bus.dcache_flush_i) begin
          w_state_nxt = c_flush_rd;
        end else if (bus.lsummu2dcache_req_i) begin
          w_dreq      = 1'b1;
          w_state_nxt = c_lookup;
        end
      end
      c_lookup: begin
        if (bus.cache_hit_i) begin
          w_cwr       = r_wr;
          w_lsu_ack   = 1'b1;
          w_state_nxt = c_idle;
        end else if (bus.dcache_valid_i && bus.cache_evict_req_i) begin
          w_state_nxt = c_wrback;
        end else if (bus.victim_hit_i) begin
          w_state_nxt = c_vfill;
        end else if (bus.dcache_valid_i) begin
          w_state_nxt = c_vstore;
        end else begin
          w_state_nxt = c_allocate;
        end
      end
      c_wrback: begin
        w_mem_req = 1'b1;
        w_mem_wr  = 1'b1;
        w_wrb     = 1'b1;
        if (bus.mem2dcache_ack_i) w_state_nxt = r_vhit ? c_vfill : c_allocate;
      end
      c_vstore: begin
        w_to_v      = 1'b1;
        w_state_nxt = c_allocate;
      end
      c_allocate: begin
        w_mem_req = 1'b1;
        if (bus.mem2dcache_ack_i) begin
          w_line_wr   = 1'b1;
          w_state_nxt = c_replay;
        end
      end
      c_vfill: begin
        w_from_v    = 1'b1;
        w_mux       = 1'b1;
        w_to_v      = r_vclean;
        w_state_nxt = c_replay;
      end
      c_replay: begin
        w_dreq      = 1'b1;
        w_state_nxt = c_lookup;
      end
      c_flush_rd: begin
        w_dreq      = 1'b1;
        w_state_nxt = c_flush_chk;
      end
      c_flush_chk: begin
        if (bus.dcache_valid_i && bus.cache_evict_req_i) begin
          w_state_nxt = c_flush_wb;
        end else begin
          w_line_done = 1'b1;
          w_state_nxt = (r_idx == c_idx_max) ? c_flush_done : c_flush_rd;
        end
      end
      c_flush_wb: begin
        w_mem_req = 1'b1;
        w_mem_wr  = 1'b1;
        w_wrb     = 1'b1;
        if (bus.mem2dcache_ack_i) w_state_nxt = c_flush_clean;
      end
      c_flush_clean: begin
        w_clean     = 1'b1;
        w_line_done = 1'b1;
        w_state_nxt = (r_idx == c_idx_max) ? c_flush_done : c_flush_rd;
      end
      c_flush_done: begin
        w_flush_ack = 1'b1;
        w_state_nxt = c_idle;
      end
      default: w_state_nxt = c_idle;
    endcase
  end

  // Reset silences the Mealy outputs too, since IDLE still decodes the live request input
  assign bus.dcache2lsummu_ack_o  = w_lsu_ack   && !rst;
  assign bus.dcache_flush_ack_o   = w_flush_ack && !rst;
  assign bus.dcache2mem_req_o     = w_mem_req   && !rst;
  assign bus.dcache2mem_wr_o      = w_mem_wr    && !rst;
  assign bus.dcache_req_o         = w_dreq      && !rst;
  assign bus.cache_wr_o           = w_cwr       && !rst;
  assign bus.cache_line_wr_o      = w_line_wr   && !rst;
  assign bus.cache_line_clean_o   = w_clean     && !rst;
  assign bus.cache_wrb_req_o      = w_wrb       && !rst;
  assign bus.write_to_victim_o    = w_to_v      && !rst;
  assign bus.write_from_victim_o  = w_from_v    && !rst;
  assign bus.lsu_victim_mux_sel_o = w_mux       && !rst;
  assign bus.evict_index_o        = r_idx;
endmodule
`default_nettype wire

// File: doc/wb_dcache_victim_ctrl.md
WB_DCACHE_VICTIM_CTRL -- requirements
Module: wb_dcache_victim_ctrl

Interface
REQ-001 SHALL have parameter IDX_BITS, default 7, width of the dcache line index (2^IDX_BITS lines).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port lsummu2dcache_req_i  input  1  LSU/MMU request, held high until acked.
REQ-005 SHALL have port lsummu2dcache_wr_i  input  1  request is a store; sampled when the request is accepted.
REQ-006 SHALL have port dcache_flush_i  input  1  flush request, held high until acked.
REQ-007 SHALL have ports cache_hit_i, cache_evict_req_i (line dirty), dcache_valid_i, victim_hit_i  input  1 each  datapath lookup status, valid in LOOKUP/FLUSH_CHK.
REQ-008 SHALL have port mem2dcache_ack_i  input  1  memory transfer complete.
REQ-009 SHALL have ports dcache2lsummu_ack_o, dcache_flush_ack_o  output  1 each  one-cycle completion pulses.
REQ-010 SHALL have ports dcache2mem_req_o, dcache2mem_wr_o  output  1 each  memory request, write-back qualifier.
REQ-011 SHALL have ports dcache_req_o, cache_wr_o, cache_line_wr_o, cache_line_clean_o, cache_wrb_req_o  output  1 each  datapath RAM enable and write controls.
REQ-012 SHALL have ports write_to_victim_o, write_from_victim_o, lsu_victim_mux_sel_o  output  1 each  victim cache controls.
REQ-013 SHALL have port evict_index_o  output  IDX_BITS  flush line index.

Function
REQ-014 SHALL implement states IDLE, LOOKUP, WRBACK, VSTORE, ALLOCATE, VFILL, REPLAY, FLUSH_RD, FLUSH_CHK, FLUSH_WB, FLUSH_CLEAN, FLUSH_DONE.
REQ-015 IDLE: dcache_flush_i -> FLUSH_RD (flush wins over simultaneous request); else lsummu2dcache_req_i -> dcache_req_o=1, latch wr and victim-hit flag clear, -> LOOKUP.
REQ-016 LOOKUP hit: store -> cache_wr_o=1 one cycle; load or store -> dcache2lsummu_ack_o=1 same cycle, -> IDLE (hit latency 2 cycles from request acceptance).
REQ-017 LOOKUP miss: latch victim_hit_i; valid and dirty -> WRBACK; valid and clean with victim miss -> VSTORE; victim hit -> VFILL; invalid -> ALLOCATE.
REQ-018 WRBACK: dcache2mem_req_o=1, dcache2mem_wr_o=1, cache_wrb_req_o=1 held until mem2dcache_ack_i; then latched victim hit -> VFILL else ALLOCATE.
REQ-019 VSTORE: write_to_victim_o=1 exactly one cycle, -> ALLOCATE.
REQ-020 ALLOCATE: dcache2mem_req_o=1, dcache2mem_wr_o=0 until ack; ack cycle asserts cache_line_wr_o=1, -> REPLAY.
REQ-021 VFILL: one cycle write_from_victim_o=1, lsu_victim_mux_sel_o=1, write_to_victim_o=1 only if line valid and clean at LOOKUP; -> REPLAY.
REQ-022 REPLAY: dcache_req_o=1, -> LOOKUP; replayed lookup hits and completes per REQ-016.
REQ-023 Flush: 7-bit (IDX_BITS) counter drives evict_index_o, starts 0; FLUSH_RD dcache_req_o=1 -> FLUSH_CHK; dirty -> FLUSH_WB (as WRBACK) -> FLUSH_CLEAN (cache_line_clean_o=1 one cycle); clean -> skip write-back.
REQ-024 After each line: index == 2^IDX_BITS-1 -> FLUSH_DONE (dcache_flush_ack_o=1 one cycle, counter to 0, -> IDLE); else index+1 -> FLUSH_RD; no wrap past max.
REQ-025 mem2dcache_ack_i while dcache2mem_req_o=0 SHALL be ignored; requests arriving outside IDLE SHALL wait.
REQ-026 All strobes other than memory request SHALL be single-cycle; no two of cache_wr_o, cache_line_wr_o, write_from_victim_o asserted together.

Reset
REQ-027 rst high SHALL immediately force IDLE, counter 0, latched flags 0, every output 0, including mid write-back (memory request dropped).
REQ-028 First request accepted on the first clk edge after rst deasserts.

Verification
REQ-029 Load hit: req=1,wr=0, hit=1 in LOOKUP -> ack at cycle 2, no memory request, no cache writes.
REQ-030 Store miss, dirty, victim miss: -> WRBACK held 3 cycles until ack, ALLOCATE, cache_line_wr_o pulse, REPLAY, cache_wr_o + ack.
REQ-031 Load miss, clean valid line, victim_hit=1 -> VFILL with write_from_victim_o=write_to_victim_o=lsu_victim_mux_sel_o=1 one cycle, no memory request, ack after replay.
REQ-032 Flush with IDX_BITS=2, lines 1 and 3 dirty -> exactly 2 write-backs at evict_index 1 and 3, 2 clean pulses, one flush ack, index back to 0.
REQ-033 Flush and request together in IDLE -> flush completes first, then request serviced.
REQ-034 rst asserted during WRBACK -> same-cycle outputs 0, IDLE; late mem ack ignored.
